// File: rtl/argmax_pkg.sv
// Shared types and default sizing for the classifier argmax stage.
package argmax_pkg;
  typedef enum logic [0:0] {S_ACCUM, S_HOLD} argmax_state_t;

  localparam int DEF_DATA_W      = 11;
  localparam int DEF_NUM_CLASSES = 10;
endpackage

// File: rtl/argmax_stream_if.sv
// Score-in / result-out handshake bundle for argmax_stream.
interface argmax_stream_if
  import argmax_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = $clog2(DEF_NUM_CLASSES)
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_max;
  logic              out_len_err;

  // master: score producer + result consumer; slave: the argmax unit
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_idx, out_max, out_len_err
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_idx, out_max, out_len_err
  );
endinterface

// File: rtl/argmax_cmp.sv
// One compare step of the running argmax; ties resolve to the newer index.
module argmax_cmp #(
  parameter int DATA_W = 11,
  parameter int IDX_W  = 4
) (
  input  logic signed [DATA_W-1:0] cur_max_i,
  input  logic        [IDX_W-1:0]  cur_idx_i,
  input  logic signed [DATA_W-1:0] new_data_i,
  input  logic        [IDX_W-1:0]  new_idx_i,
  input  logic                     first_i,
  output logic signed [DATA_W-1:0] nxt_max_o,
  output logic        [IDX_W-1:0]  nxt_idx_o
);
  logic take;

  assign take      = first_i || (new_data_i >= cur_max_i);
  assign nxt_max_o = take ? new_data_i : cur_max_i;
  assign nxt_idx_o = take ? new_idx_i  : cur_idx_i;
endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax over NUM_CLASSES signed scores per frame, registered result
// with frame-length error flag.
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input logic           Clk,
  input logic           Reset_n,
  argmax_stream_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_CLASSES - 1);

  argmax_state_t      state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  max_q, max_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ovld_q, ovld_d;
  logic [IDX_W-1:0]   oidx_q, oidx_d;
  logic [DATA_W-1:0]  omax_q, omax_d;
  logic               oerr_q, oerr_d;

  logic               accept, eof;
  logic signed [DATA_W-1:0] cmp_max;
  logic        [IDX_W-1:0]  cmp_idx;

  argmax_cmp #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_cmp (
    .cur_max_i  (max_q),
    .cur_idx_i  (idx_q),
    .new_data_i (bus.in_data),
    .new_idx_i  (cnt_q),
    .first_i    (cnt_q == '0),
    .nxt_max_o  (cmp_max),
    .nxt_idx_o  (cmp_idx)
  );

  // in_ready decodes registered state only, never out_ready
  assign bus.in_ready    = (state_q == S_ACCUM);
  assign bus.out_valid   = ovld_q;
  assign bus.out_idx     = oidx_q;
  assign bus.out_max     = omax_q;
  assign bus.out_len_err = oerr_q;

  assign accept = bus.in_valid && (state_q == S_ACCUM);
  assign eof    = bus.in_last || (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    idx_d   = idx_q;
    ovld_d  = ovld_q;
    oidx_d  = oidx_q;
    omax_d  = omax_q;
    oerr_d  = oerr_q;
    unique case (state_q)
      S_ACCUM: begin
        if (accept) begin
          max_d = cmp_max;
          idx_d = cmp_idx;
          cnt_d = cnt_q + IDX_W'(1);
          if (eof) begin
            oidx_d  = cmp_idx;
            omax_d  = cmp_max;
            oerr_d  = !(bus.in_last && (cnt_q == LAST_CNT));
            ovld_d  = 1'b1;
            state_d = S_HOLD;
            cnt_d   = '0;
          end
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          ovld_d  = 1'b0;
          state_d = S_ACCUM;
        end
      end
      default: state_d = S_ACCUM;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_ACCUM;
      cnt_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      ovld_q  <= 1'b0;
      oidx_q  <= '0;
      omax_q  <= '0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      ovld_q  <= ovld_d;
      oidx_q  <= oidx_d;
      omax_q  <= omax_d;
      oerr_q  <= oerr_d;
    end
  end
endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream: scoreboard of expected frame results,
// popped by a monitor on each output handshake.
module tb_argmax_stream;
  localparam int DATA_W = 11;
  localparam int NUM    = 10;
  localparam int IDX_W  = 4;

  typedef struct {int idx; int mx; int err;} exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  argmax_stream_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  argmax_stream #(.DATA_W(DATA_W), .NUM_CLASSES(NUM), .IDX_W(IDX_W)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // result monitor: handshake completes at the next rising edge
  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      exp_t e;
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL sb_unexpected observed=%0d expected=%0d", sb.size(), 1);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_idx", bus.out_idx, e.idx);
        chk("out_max", $signed(bus.out_max), e.mx);
        chk("out_len_err", bus.out_len_err, e.err);
      end
    end
  end

  task automatic push_exp(input int sc[$], input bit use_last);
    exp_t e;
    e.mx = sc[0];
    e.idx = 0;
    for (int i = 1; i < sc.size(); i++)
      if (sc[i] >= e.mx) begin
        e.mx  = sc[i];
        e.idx = i;
      end
    e.err = (use_last && sc.size() == NUM) ? 0 : 1;
    sb.push_back(e);
  endtask

  // called at posedge+1; returns at posedge+1 right after acceptance
  task automatic send_beat(input int d, input bit last);
    int budget = 100;
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(d);
    bus.in_last  = last;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      budget--;
      if (budget == 0) begin
        chk("in_ready_wait", bus.in_ready, 1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input int sc[$], input bit use_last, input bit gaps);
    push_exp(sc, use_last);
    for (int i = 0; i < sc.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
      if (gaps) #1;
      send_beat(sc[i], use_last && i == sc.size() - 1);
    end
    chk("lat_out_valid", bus.out_valid, 1);
    chk("hold_in_ready", bus.in_ready, 0);
    if (bus.out_ready === 1'b1) begin
      @(posedge clk); #1;
      chk("rel_in_ready", bus.in_ready, 1);
      chk("rel_out_valid", bus.out_valid, 0);
    end
  endtask

  initial begin
    int q[$];
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_out_max", $signed(bus.out_max), 0);
    chk("rst_out_len_err", bus.out_len_err, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic frame, tie goes to later index
    q = '{3, -7, 12, 0, 5, 12, -1, 4, 9, 2};
    send_frame(q, 1'b1, 1'b0);

    // all negative under backpressure
    bus.out_ready = 1'b0;
    q = '{-1024, -3, -500, -3, -900, -1000, -1024, -20, -3, -7};
    send_frame(q, 1'b1, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_idx", bus.out_idx, 8);
      chk("bp_out_max", $signed(bus.out_max), -3);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_out_valid", bus.out_valid, 0);
    chk("bp_rel_in_ready", bus.in_ready, 1);

    // short frame, then truncated frame without in_last
    q = '{1, 9, 2, 3};
    send_frame(q, 1'b1, 1'b0);
    q = '{4, 4, -2, 100, 6, -100, 99, 100, 0, 1};
    send_frame(q, 1'b0, 1'b0);

    // single-beat frame
    q = '{-5};
    send_frame(q, 1'b1, 1'b0);

    // reset mid-frame discards the partial max
    send_beat(10, 1'b0);
    send_beat(20, 1'b0);
    send_beat(50, 1'b0);
    send_beat(30, 1'b0);
    send_beat(40, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_out_valid", bus.out_valid, 0);
    q = '{1, 2, 3, -4, 5, 0, 7, 6, -8, 2};
    send_frame(q, 1'b1, 1'b0);

    // reset while holding a result drops it
    bus.out_ready = 1'b0;
    q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    send_frame(q, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    void'(sb.pop_back());
    chk("holdrst_out_valid", bus.out_valid, 0);
    chk("holdrst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;

    // back-to-back frames with random valid gaps
    q = '{-1, 1023, -1024, 1023, 0, 5, 5, 5, 1, 2};
    send_frame(q, 1'b1, 1'b1);
    q = '{7, 6, 5, 4, 3, 2, 1, 0, -1, -2};
    send_frame(q, 1'b1, 1'b1);
    q = '{-9, -8, -8, -9, -100, -8, -50, -60, -70, -80};
    send_frame(q, 1'b1, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
